stepped_clock_ctrl: RTL and testbench

Parametrised processor clock-enable generator. It replaces the switch-driven slow clock that feeds the soft processor. It runs in one `CLK` domain and emits a single-cycle `SCLK_EN` strobe for the core, instead of a derived clock. Four modes are supported: halt, free-run at a selectable power-of-two rate, debounced single-step, and fixed-length burst. An enable-tick counter is exported for LED/7-seg display.

---
 rtl/stepped_clock_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_stepped_clock_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepped_clock_ctrl.sv
// ---------------------------------------------------------------------------
// stepped_clock_ctrl
//
// Clock-enable generator for the soft processor. Everything runs in the CLK
// domain. Instead of deriving a slow clock, it emits a one-cycle SCLK_EN
// strobe that the core uses as its clock enable.
//
// Modes (MODE):
//   00 halt        : no strobes, divider parked at 0
//   01 free-run    : one strobe every P = BASE_DIV << RATE_SEL cycles
//   10 single-step : one strobe per debounced press of STEP_BTN
//   11 burst       : a press launches BURST_LEN strobes spaced P apart
//
// Ports:
//   CLK        in   system clock, rising edge
//   CPU_RESETN in   synchronous active-low reset
//   MODE       in   [1:0] mode select (see above)
//   RATE_SEL   in   [SEL_W-1:0] free-run / burst period select
//   STEP_BTN   in   raw asynchronous pushbutton, active-high
//   SCLK_EN    out  registered one-cycle enable strobe to the processor
//   BUSY       out  registered, high while a burst is in progress
//   TICK_COUNT out  [CNT_W-1:0] count of SCLK_EN strobes, wrapping
// ---------------------------------------------------------------------------
module stepped_clock_ctrl #(
    parameter int BASE_DIV  = 1,
    parameter int SEL_W     = 4,
    parameter int DIV_W     = 32,
    parameter int DB_CYCLES = 1000000,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic [1:0]       MODE,
    input  logic [SEL_W-1:0] RATE_SEL,
    input  logic             STEP_BTN,
    output logic             SCLK_EN,
    output logic             BUSY,
    output logic [CNT_W-1:0] TICK_COUNT
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int REM_W = $clog2(BURST_LEN + 1);

    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } burst_state_t;

    // Period in CLK cycles for a given rate select. When the shifted value
    // is exactly 2^DIV_W it wraps to 0, and 0 - 1 is the all-ones terminal
    // count, so the full-range period still works.
    function automatic logic [DIV_W-1:0] period_of(input logic [SEL_W-1:0] sel);
        return DIV_W'(BASE_DIV) << sel;
    endfunction

    // -----------------------------------------------------------------------
    // Button synchronizer (stage p0 -> p1)
    // -----------------------------------------------------------------------
    logic btn_sync_p0;
    logic btn_sync_p1;

    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            btn_sync_p0 <= 1'b0;
            btn_sync_p1 <= 1'b0;
        end else begin
            btn_sync_p0 <= STEP_BTN;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce and rising-edge request
    // -----------------------------------------------------------------------
    logic            db_level_q;
    logic            db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            step_req_q;

    // The debounced level moves only after the synced level has disagreed
    // with it for DB_CYCLES consecutive cycles. Any agreement restarts the
    // count, so bounces shorter than that never get through.
    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
            step_req_q <= 1'b0;
        end else begin
            if (btn_sync_p1 != db_level_q) begin
                if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    db_level_q <= btn_sync_p1;
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
            db_prev_q  <= db_level_q;
            // One-cycle request on a debounced press; releases are ignored.
            step_req_q <= db_level_q & ~db_prev_q;
        end
    end

    // -----------------------------------------------------------------------
    // Divider, burst FSM and strobe: state register
    // -----------------------------------------------------------------------
    burst_state_t     state_q;
    burst_state_t     state_d;
    logic [1:0]       mode_q;
    logic [SEL_W-1:0] rate_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_d;
    logic             sclk_q;
    logic             pulse_d;
    logic [CNT_W-1:0] tick_q;

    always_ff @(posedge CLK) begin
        // The mode/rate copies follow the inputs even during reset, so
        // releasing reset is not mistaken for a mode or rate change.
        mode_q <= MODE;
        rate_q <= RATE_SEL;
        if (!CPU_RESETN) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            sclk_q  <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            sclk_q  <= pulse_d;
            if (pulse_d) begin
                tick_q <= tick_q + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] period;
    logic             term;
    logic             mode_chg;
    logic             rate_chg;

    always_comb begin
        period   = period_of(RATE_SEL);
        term     = (div_q == (period - DIV_W'(1)));
        mode_chg = (MODE != mode_q);
        rate_chg = (RATE_SEL != rate_q);

        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        pulse_d = 1'b0;

        if (mode_chg) begin
            // A mode change resets everything and also swallows any
            // step request landing in the same cycle.
            div_d   = '0;
            rem_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (MODE)
                MODE_HALT: begin
                    div_d = '0;
                end
                MODE_FREE: begin
                    // A rate change takes priority over a coincident tick,
                    // so the next strobe is exactly P_new cycles away.
                    if (rate_chg) begin
                        div_d = '0;
                    end else if (term) begin
                        div_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                MODE_STEP: begin
                    div_d   = '0;
                    pulse_d = step_req_q;
                end
                MODE_BURST: begin
                    if (state_q == ST_IDLE) begin
                        div_d = '0;
                        if (step_req_q) begin
                            rem_d   = REM_W'(BURST_LEN);
                            state_d = ST_BUSY;
                        end
                    end else begin
                        // Requests arriving mid-burst are simply not looked at.
                        if (rate_chg) begin
                            div_d = '0;
                        end else if (term) begin
                            div_d   = '0;
                            pulse_d = 1'b1;
                            rem_d   = rem_q - REM_W'(1);
                            if (rem_q == REM_W'(1)) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            div_d = div_q + DIV_W'(1);
                        end
                    end
                end
                default: begin
                    div_d = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, all straight from registers
    // -----------------------------------------------------------------------
    always_comb begin
        SCLK_EN    = sclk_q;
        BUSY       = (state_q == ST_BUSY);
        TICK_COUNT = tick_q;
    end

endmodule

// File: tb/tb_stepped_clock_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for stepped_clock_ctrl.
// DUT built with BASE_DIV=1, DB_CYCLES=8, BURST_LEN=3, CNT_W=4, so that
// RATE_SEL=0 gives P=1, RATE_SEL=2 gives P=4, RATE_SEL=3 gives P=8 and
// RATE_SEL=4 gives P=16.
// Cycle numbering: after reset release, the first edge is cycle 1. For
// button scenarios, the first edge that samples the pressed button is
// index 0. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_stepped_clock_ctrl;

    logic       CLK;
    logic       CPU_RESETN;
    logic [1:0] MODE;
    logic [3:0] RATE_SEL;
    logic       STEP_BTN;
    logic       SCLK_EN;
    logic       BUSY;
    logic [3:0] TICK_COUNT;

    int checks = 0;
    int passes = 0;

    stepped_clock_ctrl #(
        .BASE_DIV (1),
        .SEL_W    (4),
        .DIV_W    (32),
        .DB_CYCLES(8),
        .BURST_LEN(3),
        .CNT_W    (4)
    ) dut (
        .CLK       (CLK),
        .CPU_RESETN(CPU_RESETN),
        .MODE      (MODE),
        .RATE_SEL  (RATE_SEL),
        .STEP_BTN  (STEP_BTN),
        .SCLK_EN   (SCLK_EN),
        .BUSY      (BUSY),
        .TICK_COUNT(TICK_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step_clk();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] m, input logic [3:0] r);
        CPU_RESETN = 1'b0;
        MODE       = m;
        RATE_SEL   = r;
        STEP_BTN   = 1'b0;
        repeat (3) step_clk();
        CPU_RESETN = 1'b1;
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0;
        MODE       = 2'b01;
        RATE_SEL   = 4'd0;
        STEP_BTN   = 1'b0;
        repeat (2) step_clk();
        checks++;
        if (SCLK_EN !== 1'b0) $display("FAIL reset_sclk_en got=%b want=0", SCLK_EN);
        else passes++;
        checks++;
        if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", BUSY);
        else passes++;
        checks++;
        if (TICK_COUNT !== 4'd0) $display("FAIL reset_tick_count got=%0d want=0", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_free_run();
        logic exp_en;
        apply_reset(2'b01, 4'd2);
        for (int c = 1; c <= 40; c++) begin
            step_clk();
            exp_en = (c % 4 == 0);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL free_run_en cycle=%0d got=%b want=%b", c, SCLK_EN, exp_en);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd10) $display("FAIL free_run_count got=%0d want=10", TICK_COUNT);
        else passes++;
        // Reset asserted mid-run clears everything at the next edge.
        CPU_RESETN = 1'b0;
        step_clk();
        checks++;
        if (SCLK_EN !== 1'b0 || BUSY !== 1'b0 || TICK_COUNT !== 4'd0)
            $display("FAIL midrun_reset got en=%b busy=%b cnt=%0d want 0/0/0", SCLK_EN, BUSY, TICK_COUNT);
        else passes++;
        CPU_RESETN = 1'b1;
    endtask

    task automatic test_rate_change();
        logic exp_en;
        apply_reset(2'b01, 4'd2);
        for (int c = 1; c <= 60; c++) begin
            if (c == 6) RATE_SEL = 4'd4;
            step_clk();
            exp_en = (c == 4) || (c >= 22 && ((c - 22) % 16 == 0));
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL rate_change_en cycle=%0d got=%b want=%b", c, SCLK_EN, exp_en);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd4) $display("FAIL rate_change_count got=%0d want=4", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_single_step();
        logic exp_en;
        apply_reset(2'b10, 4'd2);
        // 5-cycle glitch: rejected.
        for (int i = 0; i < 40; i++) begin
            STEP_BTN = (i < 5);
            step_clk();
            checks++;
            if (SCLK_EN !== 1'b0) $display("FAIL glitch_en idx=%0d got=%b want=0", i, SCLK_EN);
            else passes++;
        end
        // Held press: one strobe at index 11.
        for (int i = 0; i < 20; i++) begin
            STEP_BTN = 1'b1;
            step_clk();
            exp_en = (i == 11);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL press_en idx=%0d got=%b want=%b", i, SCLK_EN, exp_en);
            else passes++;
        end
        // Release: nothing.
        for (int i = 0; i < 30; i++) begin
            STEP_BTN = 1'b0;
            step_clk();
            checks++;
            if (SCLK_EN !== 1'b0) $display("FAIL release_en idx=%0d got=%b want=0", i, SCLK_EN);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd1) $display("FAIL single_step_count got=%0d want=1", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_burst();
        logic exp_en;
        logic exp_busy;
        apply_reset(2'b11, 4'd2);
        for (int i = 0; i <= 35; i++) begin
            STEP_BTN = (i < 10);
            step_clk();
            exp_en   = (i == 15) || (i == 19) || (i == 23);
            exp_busy = (i >= 11) && (i < 23);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL burst_en idx=%0d got=%b want=%b", i, SCLK_EN, exp_en);
            else passes++;
            checks++;
            if (BUSY !== exp_busy) $display("FAIL burst_busy idx=%0d got=%b want=%b", i, BUSY, exp_busy);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd3) $display("FAIL burst_count got=%0d want=3", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic exp_en;
        logic exp_busy;
        // P=16 so a second debounced press can land inside the burst.
        apply_reset(2'b11, 4'd4);
        for (int i = 0; i <= 70; i++) begin
            STEP_BTN = (i < 10) || (i >= 20 && i < 32);
            step_clk();
            exp_en   = (i == 27) || (i == 43) || (i == 59);
            exp_busy = (i >= 11) && (i < 59);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL b2b_en idx=%0d got=%b want=%b", i, SCLK_EN, exp_en);
            else passes++;
            checks++;
            if (BUSY !== exp_busy) $display("FAIL b2b_busy idx=%0d got=%b want=%b", i, BUSY, exp_busy);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd3) $display("FAIL b2b_count got=%0d want=3", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_abort();
        logic exp_en;
        logic exp_busy;
        apply_reset(2'b11, 4'd2);
        for (int i = 0; i <= 45; i++) begin
            STEP_BTN = (i < 10);
            if (i >= 31)      MODE = 2'b01;
            else if (i >= 17) MODE = 2'b00;
            else              MODE = 2'b11;
            step_clk();
            exp_en   = (i == 15) || (i == 35) || (i == 39) || (i == 43);
            exp_busy = (i >= 11) && (i < 17);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL abort_en idx=%0d got=%b want=%b", i, SCLK_EN, exp_en);
            else passes++;
            checks++;
            if (BUSY !== exp_busy) $display("FAIL abort_busy idx=%0d got=%b want=%b", i, BUSY, exp_busy);
            else passes++;
        end
        checks++;
        if (TICK_COUNT !== 4'd4) $display("FAIL abort_count got=%0d want=4", TICK_COUNT);
        else passes++;
    endtask

    task automatic test_simultaneous();
        logic exp_en;
        // Mode change in the same cycle as a step request: request dropped.
        apply_reset(2'b10, 4'd2);
        for (int i = 0; i <= 25; i++) begin
            STEP_BTN = (i < 12);
            MODE     = (i >= 11) ? 2'b01 : 2'b10;
            step_clk();
            exp_en = (i == 15) || (i == 19) || (i == 23);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL mode_vs_req_en idx=%0d got=%b want=%b", i, SCLK_EN, exp_en);
            else passes++;
        end
        // Rate change on the terminal-count cycle: tick suppressed.
        apply_reset(2'b01, 4'd2);
        for (int c = 1; c <= 20; c++) begin
            RATE_SEL = (c >= 8) ? 4'd3 : 4'd2;
            step_clk();
            exp_en = (c == 4) || (c == 16);
            checks++;
            if (SCLK_EN !== exp_en) $display("FAIL rate_vs_tick_en cycle=%0d got=%b want=%b", c, SCLK_EN, exp_en);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt;
        apply_reset(2'b01, 4'd0);
        for (int c = 1; c <= 20; c++) begin
            step_clk();
            exp_cnt = 4'(c % 16);
            checks++;
            if (SCLK_EN !== 1'b1) $display("FAIL wrap_en cycle=%0d got=%b want=1", c, SCLK_EN);
            else passes++;
            checks++;
            if (TICK_COUNT !== exp_cnt) $display("FAIL wrap_count cycle=%0d got=%0d want=%0d", c, TICK_COUNT, exp_cnt);
            else passes++;
        end
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        MODE       = 2'b00;
        RATE_SEL   = 4'd0;
        STEP_BTN   = 1'b0;
        test_reset();
        test_free_run();
        test_rate_change();
        test_single_step();
        test_burst();
        test_back_to_back();
        test_abort();
        test_simultaneous();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
